// File: rtl/qpsk_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qpsk_modulator
//  Purpose  : QPSK transmitter. Accepts 2-bit symbols over valid/ready, emits
//             a head sample, then 32 carrier samples per symbol.
//             Consecutive symbols are sent back to back with no gap and no
//             second head.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-high reset
//             sym_in     - symbol; bit0=1 -> +sin (I), bit1=1 -> -cos (Q)
//             sym_valid  - sym_in valid
//             sym_ready  - block accepts sym_in this clock
//             mod_out    - registered 9-bit two's complement sample
//             sample_stb - 1-clk pulse on the first clock of each new sample
//             busy       - high while sending the head or data samples
//  Config   : QPSK_SAT_EN - when defined, mod_out = sum saturated to
//             [-255,+255]; otherwise mod_out = sum >>> 1.
//  Revision : 1.0 - initial release
// ============================================================================
module qpsk_modulator #(
  parameter int              DIV      = 4,
  parameter logic signed [8:0] HEAD_VAL = 9'sd100,
  parameter int              HEAD_LEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic signed [8:0] mod_out,
  output logic              sample_stb,
  output logic              busy
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int H_W   = (HEAD_LEN > 1) ? $clog2(HEAD_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(HEAD_LEN - 1);
  localparam logic [4:0]       K_LAST   = 5'd31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic [4:0]        k_q,       k_d;
  logic [H_W-1:0]    h_q,       h_d;
  logic [1:0]        sym_q,     sym_d;
  logic signed [8:0] mod_out_q, mod_out_d;
  logic              stb_q,     stb_d;

  // First quarter wave of round(127*sin(2*pi*a/32)), a = 0..8.
  function automatic logic signed [8:0] quarter_sin(input logic [3:0] a);
    logic signed [8:0] v;
    case (a)
      4'd0:    v = 9'sd0;
      4'd1:    v = 9'sd25;
      4'd2:    v = 9'sd49;
      4'd3:    v = 9'sd71;
      4'd4:    v = 9'sd90;
      4'd5:    v = 9'sd106;
      4'd6:    v = 9'sd117;
      4'd7:    v = 9'sd125;
      4'd8:    v = 9'sd127;
      default: v = 9'sd0;
    endcase
    return v;
  endfunction

  // Full period from quarter-wave symmetry: the second eighth-pair mirrors
  // the first, and the second half is the negated first half.
  function automatic logic signed [8:0] sin_lut(input logic [4:0] k);
    logic [3:0]        a;
    logic signed [8:0] mag;
    a   = k[3] ? (4'd0 - k[3:0]) : k[3:0];  // 16 - m, modulo 16
    mag = quarter_sin(a);
    return k[4] ? -mag : mag;
  endfunction

  // cos leads sin by a quarter period; the 5-bit add wraps modulo 32.
  function automatic logic signed [8:0] cos_lut(input logic [4:0] k);
    return sin_lut(k + 5'd8);
  endfunction

  function automatic logic signed [8:0] mix(input logic [1:0] sym,
                                            input logic [4:0] k);
    logic signed [9:0] s;
    logic signed [9:0] c;
    logic signed [9:0] i_t;
    logic signed [9:0] q_t;
    logic signed [9:0] sum;
    logic signed [8:0] res;
    s   = 10'(sin_lut(k));
    c   = 10'(cos_lut(k));
    i_t = sym[0] ? s : -s;
    q_t = sym[1] ? -c : c;
    sum = i_t + q_t;
`ifdef QPSK_SAT_EN
    if (sum > 10'sd255)
      res = 9'sd255;
    else if (sum < -10'sd255)
      res = -9'sd255;
    else
      res = sum[8:0];
`else
    // Dropping the LSB of the 10-bit sum is an arithmetic shift right.
    res = sum[9:1];
`endif
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    k_d       = k_q;
    h_d       = h_q;
    sym_d     = sym_q;
    mod_out_d = mod_out_q;
    stb_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mod_out_d = 9'sd0;
        if (sym_valid) begin
          sym_d     = sym_in;
          state_d   = ST_HEAD;
          div_d     = '0;
          h_d       = '0;
          mod_out_d = HEAD_VAL;
          stb_d     = 1'b1;
        end
      end

      ST_HEAD: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (h_q == H_LAST) begin
            state_d   = ST_DATA;
            k_d       = 5'd0;
            mod_out_d = mix(sym_q, 5'd0);
            stb_d     = 1'b1;
          end else begin
            h_d       = h_q + 1'b1;
            mod_out_d = HEAD_VAL;
            stb_d     = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (k_q == K_LAST) begin
            k_d = 5'd0;
            if (sym_valid) begin
              // Gapless continuation straight into the next symbol.
              sym_d     = sym_in;
              mod_out_d = mix(sym_in, 5'd0);
              stb_d     = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              mod_out_d = 9'sd0;
            end
          end else begin
            k_d       = k_q + 5'd1;
            mod_out_d = mix(sym_q, k_q + 5'd1);
            stb_d     = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mod_out_d = 9'sd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      k_q       <= 5'd0;
      h_q       <= '0;
      sym_q     <= 2'b00;
      mod_out_q <= 9'sd0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      k_q       <= k_d;
      h_q       <= h_d;
      sym_q     <= sym_d;
      mod_out_q <= mod_out_d;
      stb_q     <= stb_d;
    end
  end

  // Ready is derived from state so it follows reset immediately.
  assign sym_ready  = (state_q == ST_IDLE) ||
                      ((state_q == ST_DATA) && (k_q == K_LAST) && (div_q == DIV_LAST));
  assign busy       = (state_q != ST_IDLE);
  assign mod_out    = mod_out_q;
  assign sample_stb = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qpsk_modulator
//  Purpose  : Self-checking bench for qpsk_modulator with a sample scoreboard
//             and a correlating symbol decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qpsk_modulator;

  localparam int DIV      = 4;
  localparam int HEAD_LEN = 1;
  localparam int HEAD_V   = 100;
  localparam real PI      = 3.14159265358979;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        sym_in;
  logic              sym_valid;
  logic              sym_ready;
  logic signed [8:0] mod_out;
  logic              sample_stb;
  logic              busy;

  qpsk_modulator #(
    .DIV      (DIV),
    .HEAD_VAL (9'sd100),
    .HEAD_LEN (HEAD_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .mod_out    (mod_out),
    .sample_stb (sample_stb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       val;
    int       at;
    int       k;
    logic [1:0] sym;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] tx_q[$];
  int         rdy_cyc[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ci = 0;
  int         cq = 0;
  int         last_end = 0;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int s_ref(input int k);
    real v;
    v = 127.0 * $sin(2.0 * PI * k / 32.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int c_ref(input int k);
    return s_ref((k + 8) % 32);
  endfunction

  function automatic int exp_sample(input logic [1:0] sym, input int k);
    int i_v;
    int q_v;
    int sum;
    i_v = sym[0] ? s_ref(k) : -s_ref(k);
    q_v = sym[1] ? -c_ref(k) : c_ref(k);
    sum = i_v + q_v;
`ifdef QPSK_SAT_EN
    if (sum > 255) return 255;
    if (sum < -255) return -255;
    return sum;
`else
    // floor(sum/2)
    if (sum >= 0) return sum / 2;
    return -((-sum + 1) / 2);
`endif
  endfunction

  // Monitor: pop the scoreboard on every new sample, correlate data samples.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy && sym_ready) rdy_cyc.push_back(cyc);
      if (sample_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_stb", int'(mod_out), 0);
          check("unexpected_stb_flag", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample_val", int'(mod_out), e.val);
          check("sample_cyc", cyc, e.at);
          if (e.k >= 0) begin
            ci += int'(mod_out) * s_ref(e.k);
            cq += int'(mod_out) * c_ref(e.k);
            if (e.k == 31) begin
              check("decode", int'({cq < 0, ci > 0}), int'(e.sym));
              ci = 0;
              cq = 0;
            end
          end
        end
      end
    end
  end

  // Send every symbol in tx_q back to back, holding valid until each handshake.
  task automatic send_burst();
    int   wait_n;
    int   hs;
    int   base;
    exp_t e;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_in    = tx_q[0];
      #1;
      wait_n = 0;
      while (!sym_ready && wait_n < 1000) begin
        @(negedge clk);
        #1;
        wait_n++;
      end
      if (!sym_ready) begin
        check("ready_timeout", 0, 1);
        tx_q.delete();
        sym_valid = 1'b0;
        return;
      end
      hs = cyc + 1;
      if (!busy) begin
        e.val = HEAD_V; e.at = hs; e.k = -1; e.sym = tx_q[0];
        exp_q.push_back(e);
        base = hs + DIV * HEAD_LEN;
      end else begin
        base = hs;
      end
      for (int k = 0; k < 32; k++) begin
        e.val = exp_sample(tx_q[0], k);
        e.at  = base + DIV * k;
        e.k   = k;
        e.sym = tx_q[0];
        exp_q.push_back(e);
      end
      last_end = base + DIV * 32;
      void'(tx_q.pop_front());
    end
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_end_cyc"}, cyc, last_end);
    check({tag, "_idle_out"}, int'(mod_out), 0);
    check({tag, "_idle_ready"}, int'(sym_ready), 1);
  endtask

  initial begin
    reset     = 1'b1;
    sym_valid = 1'b0;
    sym_in    = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_mod_out", int'(mod_out), 0);
    check("rst_stb", int'(sample_stb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(sym_ready), 1);
    reset = 1'b0;

    // sym_in moving without valid must not start anything.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sym_in = 2'($urandom_range(0, 3));
      check("idle_hold_busy", int'(busy), 0);
      check("idle_hold_out", int'(mod_out), 0);
      check("idle_hold_stb", int'(sample_stb), 0);
    end

    // Single symbols from IDLE, one of each value.
    tx_q.push_back(2'b01); send_burst(); wait_idle("sym01");
    tx_q.push_back(2'b00); send_burst(); wait_idle("sym00");
    tx_q.push_back(2'b10); send_burst(); wait_idle("sym10");
    tx_q.push_back(2'b11); send_burst(); wait_idle("sym11");

    // Three symbols back to back: gapless, three ready pulses 128 apart.
    rdy_cyc.delete();
    tx_q.push_back(2'b10);
    tx_q.push_back(2'b01);
    tx_q.push_back(2'b11);
    send_burst();
    wait_idle("burst3");
    check("ready_pulses", rdy_cyc.size(), 3);
    if (rdy_cyc.size() == 3) begin
      check("ready_gap1", rdy_cyc[1] - rdy_cyc[0], 32 * DIV);
      check("ready_gap2", rdy_cyc[2] - rdy_cyc[1], 32 * DIV);
    end

    // Reset in the middle of a symbol.
    tx_q.push_back(2'b01);
    send_burst();
    repeat (50) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out", int'(mod_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(sym_ready), 1);
    check("midrst_stb", int'(sample_stb), 0);
    exp_q.delete();
    ci = 0;
    cq = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sym_in = 2'($urandom_range(0, 3));
      check("postrst_busy", int'(busy), 0);
      check("postrst_out", int'(mod_out), 0);
    end

    // 32 random symbols sent gapless, checked sample by sample and decoded.
    for (int i = 0; i < 32; i++) tx_q.push_back(2'($urandom_range(0, 3)));
    send_burst();
    wait_idle("rand32");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog against any hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
